// File: rtl/shift_sequencer.sv
// Shares one shift datapath between two requesters: round-robin grant in IDLE,
// then one power-of-two pass (8/4/2/1) per clock until the count is consumed.
module shift_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_in0,
   input  logic [1:0]       req_op0,
   input  logic [3:0]       req_cnt0,
   input  logic [WIDTH-1:0] req_in1,
   input  logic [1:0]       req_op1,
   input  logic [3:0]       req_cnt1,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_id,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_ptr;
   logic             r_id;
   logic [1:0]       r_op;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_data;

   logic             w_any_valid;
   logic             w_grant_id;
   logic             w_accept;
   logic [WIDTH-1:0] w_sel_data;
   logic [1:0]       w_sel_op;
   logic [3:0]       w_sel_cnt;
   logic [3:0]       w_pass;
   logic [3:0]       w_cnt_left;

   // Rotates use a doubled word so the wrapped bits fall out of the shift.
   function automatic logic [WIDTH-1:0] shift_pass(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       op,
                                                   input logic [3:0]       amt);
      logic [2*WIDTH-1:0] w_dbl;
      w_dbl = {d, d};
      case (op)
         2'b00:   begin w_dbl = w_dbl << amt; shift_pass = w_dbl[2*WIDTH-1:WIDTH]; end
         2'b01:   shift_pass = d << amt;
         2'b10:   begin w_dbl = w_dbl >> amt; shift_pass = w_dbl[WIDTH-1:0]; end
         2'b11:   shift_pass = d >> amt;
         default: shift_pass = d;
      endcase
   endfunction

   // Arbitration and request-side handshake; only live in IDLE.
   always_comb begin
      w_any_valid = |req_valid;
      w_grant_id  = 1'b0;
      if (req_valid == 2'b11) begin
         w_grant_id = r_ptr;
      end else begin
         w_grant_id = req_valid[1];
      end
      w_accept  = (r_state == IDLE) && w_any_valid;
      req_ready = 2'b00;
      if (w_accept) begin
         req_ready = w_grant_id ? 2'b10 : 2'b01;
      end else begin
         req_ready = 2'b00;
      end
      if (w_grant_id) begin
         w_sel_data = req_in1;
         w_sel_op   = req_op1;
         w_sel_cnt  = req_cnt1;
      end else begin
         w_sel_data = req_in0;
         w_sel_op   = req_op0;
         w_sel_cnt  = req_cnt0;
      end
   end

   // Highest remaining count bit is both the pass amount and the bit to clear.
   always_comb begin
      w_pass = 4'd0;
      if (r_cnt[3]) begin
         w_pass = 4'd8;
      end else if (r_cnt[2]) begin
         w_pass = 4'd4;
      end else if (r_cnt[1]) begin
         w_pass = 4'd2;
      end else if (r_cnt[0]) begin
         w_pass = 4'd1;
      end else begin
         w_pass = 4'd0;
      end
      w_cnt_left = r_cnt & ~w_pass;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = (w_sel_cnt != 4'd0) ? SHIFT : DONE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SHIFT: begin
            if (w_cnt_left == 4'd0) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = SHIFT;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = DONE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand latch on accept, then one pass per SHIFT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr  <= 1'b0;
         r_id   <= 1'b0;
         r_op   <= 2'b00;
         r_cnt  <= 4'd0;
         r_data <= '0;
      end else if (w_accept) begin
         r_ptr  <= ~w_grant_id;
         r_id   <= w_grant_id;
         r_op   <= w_sel_op;
         r_cnt  <= w_sel_cnt;
         r_data <= w_sel_data;
      end else if (r_state == SHIFT) begin
         r_data <= shift_pass(r_data, r_op, w_pass);
         r_cnt  <= w_cnt_left;
      end
   end

   assign rsp_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign rsp_data  = r_data;
   assign rsp_id    = r_id;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected {id,data} queued at accept,
// popped and compared when the response appears.
module tb_shift_sequencer;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_in0, req_in1;
   logic [1:0]  req_op0, req_op1;
   logic [3:0]  req_cnt0, req_cnt1;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [15:0] rsp_data;

   int          errors = 0;
   int          checks = 0;
   logic [16:0] exp_q[$];

   shift_sequencer #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_in0(req_in0), .req_op0(req_op0), .req_cnt0(req_cnt0),
      .req_in1(req_in1), .req_op1(req_op1), .req_cnt1(req_cnt1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: apply one single-position step cnt times.
   function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] op,
                                         input logic [3:0] c);
      logic [15:0] r;
      r = d;
      for (int i = 0; i < int'(c); i++) begin
         case (op)
            2'b00:   r = {r[14:0], r[15]};
            2'b01:   r = {r[14:0], 1'b0};
            2'b10:   r = {r[0], r[15:1]};
            default: r = {1'b0, r[15:1]};
         endcase
      end
      return r;
   endfunction

   function automatic logic [16:0] pop_exp();
      if (exp_q.size() == 0) return 17'bx;
      return exp_q.pop_front();
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Drives one request, waits for accept and response, completes the handshake.
   task automatic xact(input int k, input logic [15:0] d, input logic [1:0] op,
                       input logic [3:0] c, output int acc_wait, output int lat,
                       output logic [15:0] dat, output logic id, output logic [16:0] e);
      acc_wait = 0; lat = 0; dat = 16'h0000; id = 1'b0; e = 17'bx;
      if (k == 0) begin req_in0 = d; req_op0 = op; req_cnt0 = c; end
      else begin req_in1 = d; req_op1 = op; req_cnt1 = c; end
      req_valid[k] = 1'b1;
      #1;
      while (req_ready[k] !== 1'b1 && acc_wait < 20) begin
         @(posedge clk); #2; acc_wait++;
      end
      if (req_ready[k] !== 1'b1) begin
         req_valid = 2'b00; acc_wait = -1;
         return;
      end
      exp_q.push_back({k[0], model(d, op, c)});
      tick();
      req_valid[k] = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
      dat = rsp_data; id = rsp_id; e = pop_exp();
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got=%h want=0000", rsp_data); end
      checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%b want=0", rsp_id); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_first();
      int aw, lat; logic [15:0] dat; logic id; logic [16:0] e;
      do_reset();
      xact(0, 16'h8001, 2'b00, 4'd1, aw, lat, dat, id, e);
      checks++; if (aw !== 0) begin errors++; $display("FAIL first_accept_wait got=%0d want=0", aw); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL first_latency got=%0d want=2", lat); end
      checks++; if (dat !== 16'h0003) begin errors++; $display("FAIL first_data got=%h want=0003", dat); end
      checks++; if ({id, dat} !== e) begin errors++; $display("FAIL first_sb got=%h want=%h", {id, dat}, e); end
   endtask

   task automatic test_ops();
      logic [1:0]  t_op[4]  = '{2'b01, 2'b10, 2'b11, 2'b00};
      logic [3:0]  t_cnt[4] = '{4'd4, 4'd1, 4'd15, 4'd0};
      logic [15:0] t_res[4] = '{16'h0010, 16'hC000, 16'h0001, 16'h8001};
      int          t_lat[4] = '{2, 2, 5, 1};
      int aw, lat; logic [15:0] dat; logic id; logic [16:0] e;
      for (int i = 0; i < 4; i++) begin
         xact(0, 16'h8001, t_op[i], t_cnt[i], aw, lat, dat, id, e);
         checks++; if (dat !== t_res[i]) begin errors++; $display("FAIL op%0d_data got=%h want=%h", i, dat, t_res[i]); end
         checks++; if (lat !== t_lat[i]) begin errors++; $display("FAIL op%0d_latency got=%0d want=%0d", i, lat, t_lat[i]); end
         checks++; if ({id, dat} !== e) begin errors++; $display("FAIL op%0d_sb got=%h want=%h", i, {id, dat}, e); end
         checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL op%0d_idle busy=%b rsp_valid=%b want 0/0", i, busy, rsp_valid); end
      end
      for (int i = 0; i < 8; i++) begin
         int k; logic [15:0] d; logic [1:0] op; logic [3:0] c;
         k = int'($urandom_range(0, 1)); d = 16'($urandom); op = 2'($urandom); c = 4'($urandom);
         xact(k, d, op, c, aw, lat, dat, id, e);
         checks++; if ({id, dat} !== e) begin errors++; $display("FAIL rnd%0d_sb got=%h want=%h", i, {id, dat}, e); end
         checks++; if (lat !== $countones(c) + 1) begin errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, $countones(c) + 1); end
      end
   endtask

   task automatic test_alternate();
      int got; logic mptr; logic [16:0] e;
      do_reset();
      req_in0 = 16'h1234; req_op0 = 2'b01; req_cnt0 = 4'd3;
      req_in1 = 16'hA5F0; req_op1 = 2'b10; req_cnt1 = 4'd5;
      req_valid = 2'b11; rsp_ready = 1'b1; mptr = 1'b0; got = 0;
      for (int t = 0; t < 80 && got < 4; t++) begin
         #1;
         checks++; if (req_ready === 2'b11) begin errors++; $display("FAIL alt_ready_onehot got=%b", req_ready); end
         if (rsp_valid === 1'b1) begin
            e = pop_exp();
            checks++; if ({rsp_id, rsp_data} !== e) begin errors++; $display("FAIL alt_rsp%0d got=%h want=%h", got, {rsp_id, rsp_data}, e); end
            got++;
         end
         if (req_ready !== 2'b00) begin
            checks++; if (req_ready !== (mptr ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_grant got=%b want=%b", req_ready, mptr ? 2'b10 : 2'b01); end
            exp_q.push_back(mptr ? {1'b1, model(req_in1, req_op1, req_cnt1)} : {1'b0, model(req_in0, req_op0, req_cnt0)});
            mptr = ~mptr;
         end
         @(posedge clk);
      end
      #1;
      req_valid = 2'b00;
      checks++; if (got !== 4) begin errors++; $display("FAIL alt_count got=%0d want=4", got); end
      tick();
      rsp_ready = 1'b0;
      tick();
   endtask

   task automatic test_hold();
      int n; logic [16:0] e;
      req_in1 = 16'h1357; req_op1 = 2'b01; req_cnt1 = 4'd2;
      req_valid = 2'b10;
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL hold_grant got=%b want=10", req_ready); end
      exp_q.push_back({1'b1, model(16'h1357, 2'b01, 4'd2)});
      tick();
      req_valid = 2'b00;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin tick(); n++; end
      e = pop_exp();
      req_in0 = 16'h0F00; req_op0 = 2'b00; req_cnt0 = 4'd1; req_valid = 2'b01;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e}) begin errors++; $display("FAIL hold%0d_rsp got=%b/%h want=1/%h", i, rsp_valid, {rsp_id, rsp_data}, e); end
         checks++; if (busy !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL hold%0d_busy busy=%b ready=%b want 1/00", i, busy, req_ready); end
         tick();
      end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_release busy=%b rsp_valid=%b want 0/0", busy, rsp_valid); end
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL hold_idle_ready got=%b want=01", req_ready); end
      req_valid = 2'b00;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_drop_valid busy=%b want=0", busy); end
   endtask

   task automatic test_reset_mid();
      int n; logic [16:0] e;
      req_in0 = 16'hFFFF; req_op0 = 2'b11; req_cnt0 = 4'd15;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();
      #2;
      rst = 1'b1; req_valid = 2'b11;
      #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state rsp_valid=%b busy=%b want 0/0", rsp_valid, busy); end
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_ready got=%b want=01", req_ready); end
      checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL rstmid_data got=%h want=0000", rsp_data); end
      #1;
      rst = 1'b0;
      exp_q.delete();
      exp_q.push_back({1'b0, model(16'hFFFF, 2'b11, 4'd15)});
      tick();
      req_valid = 2'b00;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_accept busy=%b want=1", busy); end
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin tick(); n++; end
      e = pop_exp();
      checks++; if ({rsp_id, rsp_data} !== e) begin errors++; $display("FAIL rstmid_rsp got=%h want=%h", {rsp_id, rsp_data}, e); end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
   endtask

   task automatic test_busy_ignore();
      int n; logic [16:0] e;
      req_in0 = 16'h00FF; req_op0 = 2'b01; req_cnt0 = 4'd8;
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL busy_grant0 got=%b want=01", req_ready); end
      exp_q.push_back({1'b0, model(16'h00FF, 2'b01, 4'd8)});
      tick();
      req_in1 = 16'h0F0F; req_op1 = 2'b00; req_cnt1 = 4'd6; req_valid = 2'b10;
      n = 0;
      #1;
      while (rsp_valid !== 1'b1 && n < 40) begin
         checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL busy_ready%0d got=%b want=00", n, req_ready); end
         tick(); #1; n++;
      end
      e = pop_exp();
      checks++; if ({rsp_id, rsp_data} !== e) begin errors++; $display("FAIL busy_rsp0 got=%h want=%h", {rsp_id, rsp_data}, e); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL busy_done_ready got=%b want=00", req_ready); end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL busy_grant1 got=%b want=10", req_ready); end
      exp_q.push_back({1'b1, model(16'h0F0F, 2'b00, 4'd6)});
      tick();
      req_valid = 2'b00; req_in1 = 16'h0000; req_op1 = 2'b11; req_cnt1 = 4'd1;
      n = 1;
      while (rsp_valid !== 1'b1 && n < 40) begin tick(); n++; end
      e = pop_exp();
      checks++; if ({rsp_id, rsp_data} !== e) begin errors++; $display("FAIL busy_rsp1 got=%h want=%h", {rsp_id, rsp_data}, e); end
      checks++; if (rsp_data !== 16'hC3C3) begin errors++; $display("FAIL busy_rsp1_data got=%h want=c3c3", rsp_data); end
      checks++; if (n !== 3) begin errors++; $display("FAIL busy_rsp1_latency got=%0d want=3", n); end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
      req_in0 = 16'h0000; req_op0 = 2'b00; req_cnt0 = 4'd0;
      req_in1 = 16'h0000; req_op1 = 2'b00; req_cnt1 = 4'd0;
      test_reset();
      test_first();
      test_ops();
      test_alternate();
      test_hold();
      test_reset_mid();
      test_busy_ignore();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
